// File: rtl/falling_block_array.sv
// falling_block_array: NUM_BLOCKS independent falling-block slots (spawn, fall, catch/flash, miss tally).
// Latency: spawn/hit/motion/miss take effect on the next frame_clk edge; all outputs come from registers.
// Backpressure: none; spawn to a busy slot and hit to an idle slot are dropped. Optional FALL_ACCEL_EN.
module falling_block_array #(
  parameter int NUM_BLOCKS   = 4,
  parameter int COORD_W      = 10,
  parameter int Y_MAX        = 479,
  parameter int BLOCK_SIZE   = 12,
  parameter int STEP_W       = 4,
  parameter int FLASH_FRAMES = 8
`ifdef FALL_ACCEL_EN
  // Only exists when acceleration is built, so the plain build carries no dead parameter.
  , parameter int ACCEL_PERIOD = 16
`endif
) (
  input  logic                          frame_clk,
  input  logic                          Reset,
  input  logic [NUM_BLOCKS-1:0]         spawn,
  input  logic [NUM_BLOCKS*COORD_W-1:0] spawn_x,
  input  logic [STEP_W-1:0]             step,
  input  logic [NUM_BLOCKS-1:0]         hit,
  input  logic                          pause,
  output logic [NUM_BLOCKS*COORD_W-1:0] block_x,
  output logic [NUM_BLOCKS*COORD_W-1:0] block_y,
  output logic [COORD_W-1:0]            block_s,
  output logic [NUM_BLOCKS-1:0]         active,
  output logic [NUM_BLOCKS-1:0]         caught,
  output logic [NUM_BLOCKS-1:0]         miss,
  output logic [7:0]                    miss_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FALL  = 2'd1,
    S_FLASH = 2'd2
  } slot_state_t;

  localparam int                  FC_W    = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [FC_W-1:0]     FC_LOAD = FC_W'(FLASH_FRAMES - 1);
  localparam logic [COORD_W:0]    Y_LIM   = (COORD_W+1)'(Y_MAX);
  localparam logic [COORD_W-1:0]  Y_SAT   = COORD_W'(Y_MAX);
  localparam logic [STEP_W-1:0]   STP_ONE = STEP_W'(1);
`ifdef FALL_ACCEL_EN
  localparam int                  AC_W    = (ACCEL_PERIOD > 1) ? $clog2(ACCEL_PERIOD) : 1;
  localparam logic [AC_W-1:0]     AC_LAST = AC_W'(ACCEL_PERIOD - 1);
`endif

  // A zero step would park a block forever, so it is promoted to 1 at spawn.
  logic [STEP_W-1:0] spawn_stp;
  assign spawn_stp = (step == '0) ? STP_ONE : step;

  assign block_s = COORD_W'(BLOCK_SIZE);

  // Next-edge miss of every slot, so the tally updates on the same edge the pulse appears.
  logic [NUM_BLOCKS-1:0] miss_nxt;

  for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_slot
    slot_state_t          state_q, state_d;
    logic [COORD_W-1:0]   x_q, x_d;
    logic [COORD_W-1:0]   y_q, y_d;
    logic [STEP_W-1:0]    stp_q, stp_d;
    logic [FC_W-1:0]      fcnt_q, fcnt_d;
    logic                 miss_q, miss_d;
    logic [COORD_W:0]     ny;
`ifdef FALL_ACCEL_EN
    logic [AC_W-1:0]      acnt_q, acnt_d;
`endif

    // Slot next state: spawn from idle, fall or miss, catch (hit wins), flash countdown.
    always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      stp_d   = stp_q;
      fcnt_d  = fcnt_q;
      miss_d  = 1'b0;
      // One extra bit so a step past the bottom cannot wrap back on screen.
      ny      = {1'b0, y_q} + (COORD_W+1)'(stp_q);
`ifdef FALL_ACCEL_EN
      acnt_d  = acnt_q;
`endif
      case (state_q)
        S_IDLE: begin
          if (spawn[i]) begin
            state_d = S_FALL;
            x_d     = spawn_x[i*COORD_W +: COORD_W];
            y_d     = '0;
            stp_d   = spawn_stp;
`ifdef FALL_ACCEL_EN
            acnt_d  = '0;
`endif
          end
        end
        S_FALL: begin
          if (hit[i]) begin
            state_d = S_FLASH;
            fcnt_d  = FC_LOAD;
          end else if (!pause) begin
            if (ny > Y_LIM) begin
              state_d = S_IDLE;
              y_d     = Y_SAT;
              miss_d  = 1'b1;
            end else begin
              y_d     = ny[COORD_W-1:0];
            end
`ifdef FALL_ACCEL_EN
            if (acnt_q == AC_LAST) begin
              acnt_d = '0;
              if (stp_q != '1) stp_d = stp_q + STP_ONE;
            end else begin
              acnt_d = acnt_q + AC_W'(1);
            end
`endif
          end
        end
        S_FLASH: begin
          if (!pause) begin
            if (fcnt_q == '0) state_d = S_IDLE;
            else              fcnt_d  = fcnt_q - FC_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Slot state register with asynchronous clear.
    always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
        state_q <= S_IDLE;
        x_q     <= '0;
        y_q     <= '0;
        stp_q   <= '0;
        fcnt_q  <= '0;
        miss_q  <= 1'b0;
`ifdef FALL_ACCEL_EN
        acnt_q  <= '0;
`endif
      end else begin
        state_q <= state_d;
        x_q     <= x_d;
        y_q     <= y_d;
        stp_q   <= stp_d;
        fcnt_q  <= fcnt_d;
        miss_q  <= miss_d;
`ifdef FALL_ACCEL_EN
        acnt_q  <= acnt_d;
`endif
      end
    end

    assign block_x[i*COORD_W +: COORD_W] = x_q;
    assign block_y[i*COORD_W +: COORD_W] = y_q;
    assign active[i]   = (state_q != S_IDLE);
    assign caught[i]   = (state_q == S_FLASH);
    assign miss[i]     = miss_q;
    assign miss_nxt[i] = miss_d;
  end

  // Tally of misses landing on this edge, clamped at 255.
  logic [8:0] miss_sum;
  always_comb begin
    miss_sum = {1'b0, miss_count};
    for (int k = 0; k < NUM_BLOCKS; k++) begin
      miss_sum = miss_sum + 9'(miss_nxt[k]);
    end
  end

  // Saturating miss counter register.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) miss_count <= '0;
    else       miss_count <= (miss_sum > 9'd255) ? 8'hFF : miss_sum[7:0];
  end

endmodule

// File: tb/tb_falling_block_array.sv
`timescale 1ns/1ps
module tb_falling_block_array;
  localparam int NB = 4;
  localparam int CW = 10;

  logic               frame_clk = 1'b0;
  logic               Reset;
  logic [NB-1:0]      spawn;
  logic [NB*CW-1:0]   spawn_x;
  logic [3:0]         step;
  logic [NB-1:0]      hit;
  logic               pause;
  logic [NB*CW-1:0]   block_x;
  logic [NB*CW-1:0]   block_y;
  logic [CW-1:0]      block_s;
  logic [NB-1:0]      active;
  logic [NB-1:0]      caught;
  logic [NB-1:0]      miss;
  logic [7:0]         miss_count;

  int n_assert = 0;
  int n_fail   = 0;

  falling_block_array dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .spawn      (spawn),
    .spawn_x    (spawn_x),
    .step       (step),
    .hit        (hit),
    .pause      (pause),
    .block_x    (block_x),
    .block_y    (block_y),
    .block_s    (block_s),
    .active     (active),
    .caught     (caught),
    .miss       (miss),
    .miss_count (miss_count)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] xb(input int i);
    return 32'(block_x[i*CW +: CW]);
  endfunction

  function automatic logic [31:0] yb(input int i);
    return 32'(block_y[i*CW +: CW]);
  endfunction

  // Advance n rising edges and land 1 ns after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge frame_clk);
    #1;
  endtask

  // Spawn all four slots with step 15; they overflow together 32 edges later.
  task automatic round4();
    spawn = 4'b1111;
    step  = 4'd15;
    tick(1);
    spawn = '0;
    tick(32);
  endtask

  initial begin
    Reset   = 1'b1;
    spawn   = '0;
    spawn_x = '0;
    step    = '0;
    hit     = '0;
    pause   = 1'b0;
    #3;
    chk("rst_active", 32'(active), 0);
    chk("rst_caught", 32'(caught), 0);
    chk("rst_miss",   32'(miss), 0);
    chk("rst_count",  32'(miss_count), 0);
    chk("rst_y0",     yb(0), 0);
    chk("rst_x3",     xb(3), 0);
    chk("rst_bsize",  32'(block_s), 12);
    tick(2);
    Reset = 1'b0;

    // Step 1 from x=440 to the bottom and off.
    spawn = 4'b0001; spawn_x[9:0] = 10'd440; step = 4'd1;
    tick(1);
    spawn = '0;
    chk("t1_active", 32'(active[0]), 1);
    chk("t1_x",      xb(0), 440);
    chk("t1_y0",     yb(0), 0);
    tick(479);
    chk("t1_y479",   yb(0), 479);
    chk("t1_act479", 32'(active[0]), 1);
    chk("t1_nomiss", 32'(miss), 0);
    tick(1);
    chk("t1_miss",   32'(miss), 1);
    chk("t1_idle",   32'(active[0]), 0);
    chk("t1_ysat",   yb(0), 479);
    chk("t1_count",  32'(miss_count), 1);
    tick(1);
    chk("t1_pulse1", 32'(miss), 0);
    chk("t1_count2", 32'(miss_count), 1);

    // Step 5: 475 then overflow saturates y at 479.
    spawn = 4'b0001; spawn_x[9:0] = 10'd100; step = 4'd5;
    tick(1);
    spawn = '0;
    chk("t2_y0",    yb(0), 0);
    chk("t2_x",     xb(0), 100);
    tick(95);
    chk("t2_y475",  yb(0), 475);
    tick(1);
    chk("t2_miss",  32'(miss), 1);
    chk("t2_ysat",  yb(0), 479);
    chk("t2_count", 32'(miss_count), 2);

    // Step 0 behaves as step 1.
    step = 4'd0; spawn = 4'b0001;
    tick(1);
    spawn = '0;
    chk("t2_s0_y0", yb(0), 0);
    tick(2);
    chk("t2_s0_y2", yb(0), 2);

    // Spawn to a falling slot is ignored; pause freezes motion.
    spawn = 4'b0001; spawn_x[9:0] = 10'd5; step = 4'd7;
    tick(1);
    spawn = '0;
    chk("t5_busy_x", xb(0), 100);
    chk("t5_busy_y", yb(0), 3);
    pause = 1'b1;
    tick(10);
    chk("t5_pause_y",   yb(0), 3);
    chk("t5_pause_act", 32'(active[0]), 1);
    pause = 1'b0;
    tick(1);
    chk("t5_resume_y", yb(0), 4);

    // Hit on the same edge as overflow: flash for 8 frames, no miss.
    spawn = 4'b0010; spawn_x[19:10] = 10'd200; step = 4'd15;
    tick(1);
    spawn = '0;
    chk("t3_act",  32'(active), 4'b0011);
    chk("t3_x1",   xb(1), 200);
    tick(31);
    chk("t3_y465", yb(1), 465);
    hit = 4'b0110;
    tick(1);
    chk("t3_caught", 32'(caught), 4'b0010);
    chk("t3_active", 32'(active), 4'b0011);
    chk("t3_nomiss", 32'(miss), 0);
    chk("t3_yhold",  yb(1), 465);
    chk("t3_count",  32'(miss_count), 2);
    hit = 4'b0010;
    tick(7);
    chk("t3_flash8", 32'(caught), 4'b0010);
    chk("t3_nomiss2", 32'(miss), 0);
    hit = '0;
    tick(1);
    chk("t3_done_c", 32'(caught), 0);
    chk("t3_done_a", 32'(active), 4'b0001);
    chk("t3_count2", 32'(miss_count), 2);
    chk("t3_y0",     yb(0), 45);

    // Free slot 0 through a catch.
    hit = 4'b0001;
    tick(1);
    hit = '0;
    chk("t4_c0", 32'(caught), 4'b0001);
    chk("t4_y0", yb(0), 45);
    tick(7);
    chk("t4_c0b", 32'(caught), 4'b0001);
    tick(1);
    chk("t4_free", 32'(active), 0);

    // Four simultaneous misses: 2 -> 6.
    for (int i = 0; i < NB; i++) spawn_x[i*CW +: CW] = CW'(10 * i + 10);
    spawn = 4'b1111; step = 4'd15;
    tick(1);
    spawn = '0;
    chk("t4_all_act", 32'(active), 4'b1111);
    chk("t4_x2",      xb(2), 30);
    tick(31);
    chk("t4_y3", yb(3), 465);
    tick(1);
    chk("t4_miss4",  32'(miss), 4'b1111);
    chk("t4_count6", 32'(miss_count), 6);
    chk("t4_idle",   32'(active), 0);
    chk("t4_ysat2",  yb(2), 479);

    // 62 more rounds reach 254, then saturate at 255.
    for (int r = 0; r < 62; r++) round4();
    chk("t4_count254", 32'(miss_count), 254);
    round4();
    chk("t4_sat255", 32'(miss_count), 255);
    round4();
    chk("t4_sat255b", 32'(miss_count), 255);

    // Asynchronous reset mid-fall clears everything without a clock edge.
    spawn = 4'b0001; spawn_x[9:0] = 10'd77; step = 4'd1;
    tick(1);
    spawn = '0;
    tick(100);
    chk("t5_y100", yb(0), 100);
    #2;
    Reset = 1'b1;
    #1;
    chk("t5_rst_act",   32'(active), 0);
    chk("t5_rst_y",     yb(0), 0);
    chk("t5_rst_x",     xb(0), 0);
    chk("t5_rst_count", 32'(miss_count), 0);
    chk("t5_rst_miss",  32'(miss), 0);
    Reset = 1'b0;
    tick(1);
    chk("t5_post_act", 32'(active), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
